cabac_mvd_top_ctrl: RTL and testbench
=====================================

Name: cabac_mvd_top_ctrl

Overview:
Client-side controller for the CABAC top-neighbour MVD line buffer, a 2-port RAM with one 18-bit word per MB column.
- At each macroblock start it reads the top neighbour's MVD word for the current column, registers it and presents it to the MVD context-index logic.
- After the MB is coded it writes the MB's bottom-row MVD back to the same column.
- Sits between the CABAC MB-level sequencer and the line-buffer RAM, driving that RAM's read and write ports.

Parameters:
ADDR_W, 8, line-buffer address width (column index width); matches MEM_TOP_DEPTH
FMV_W, 8, magnitude width of one MVD component; stored word is 2*(FMV_W+1) bits = {mvd_y, mvd_x}
MB_X_MAX, 255, largest legal mb_x index

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mb_start_i  in  1  one-cycle pulse: new MB begins
mb_x_i  in  ADDR_W  MB column, sampled on mb_start_i
mb_y_i  in  1  1 = MB row > 0 (top available), sampled on mb_start_i
bot_wr_i  in  1  one-cycle pulse: bottom MVD of current MB ready
bot_mvd_i  in  2*(FMV_W+1)  bottom MVD word, sampled on bot_wr_i
top_mvd_o  out  2*(FMV_W+1)  registered top-neighbour MVD
top_avail_o  out  1  top neighbour exists
top_valid_o  out  1  top_mvd_o/top_avail_o valid for current MB (level, held until next start)
busy_o  out  1  read in flight
err_o  out  1  sticky: protocol or range violation
r_en_o  out  1  RAM read enable (active-high)
r_addr_o  out  ADDR_W  RAM read address
r_data_i  in  2*(FMV_W+1)  RAM read data, valid 1 cycle after r_en_o
w_en_o  out  1  RAM write enable (active-high)
w_addr_o  out  ADDR_W  RAM write address
w_data_o  out  2*(FMV_W+1)  RAM write data

Behaviour:
- Reset: FSM=IDLE. All outputs 0. err_o cleared. Reset mid-read aborts the read; r_data_i is ignored.
- FSM states: IDLE, RD, CAP, READY.
- IDLE/READY + mb_start_i:
  - mb_y_i=0 → READY next cycle, top_mvd_o=0, top_avail_o=0, top_valid_o=1, no RAM read.
  - mb_y_i=1 → RD. top_valid_o drops to 0 the cycle after start.
- RD: r_en_o=1, r_addr_o=latched mb_x, busy_o=1, one cycle, → CAP.
- CAP: top_mvd_o<=r_data_i, top_avail_o<=1, → READY.
  - Start-to-valid latency: 3 cycles with read, 1 cycle without.
- READY: holds outputs until next mb_start_i.
- Write path, independent of FSM:
  - bot_wr_i → next cycle w_en_o=1 for one cycle.
  - w_addr_o = mb_x latched at the last start; w_data_o = bot_mvd_i.
- Simultaneous bot_wr_i and mb_start_i: the write uses the previous MB's column, latched before the start updates it. Both RAM ports may be active in the same cycle.
- err_o set on any of:
  - mb_start_i while in RD or CAP; the start is ignored.
  - mb_x_i > MB_X_MAX on start; start is ignored, FSM stays.
  - bot_wr_i before any start since reset; no write is issued.
- Read and write to the same address in the same cycle: the RAM returns old data unless the optional feature is enabled.

Optional Feature:
Macro MVD_TOP_BYPASS_EN.
- Defined:
  - In CAP, if a write to the same address was issued in the RD cycle, or is issued in CAP, top_mvd_o takes w_data_o instead of r_data_i.
  - Covers mb_x unchanged across consecutive MBs, i.e. a one-column frame.
- Undefined: no forwarding; top_mvd_o is always r_data_i.

Decomposition:
- Shared package cabac_mvd_pkg:
  - FMV_W, MVD_WORD_W = 2*(FMV_W+1), ADDR_W.
  - FSM state enum.
  - mvd word pack/unpack functions.
- One natural sub-module: cabac_mvd_top_wr_stage, the write-back register stage (latched column + data + w_en pulse). The FSM stays in the top.

Test Plan:
- mb_y_i=0, mb_x_i=5, start → r_en_o never 1; 1 cycle later top_valid_o=1, top_avail_o=0, top_mvd_o=0.
- Preload RAM col 7 = 18'h1_2345; start mb_x=7, mb_y=1 → r_en_o=1 with r_addr_o=7 at cycle+1; top_mvd_o=18'h1_2345, top_avail_o=1, top_valid_o=1 at cycle+3.
- Start mb_x=3, then bot_wr_i with 18'h0_00FF → w_en_o=1, w_addr_o=3, w_data_o=18'h0_00FF for exactly one cycle; later read of col 3 returns 18'h0_00FF.
- bot_wr_i (MB at col 4) in the same cycle as mb_start_i for col 5 → write lands at col 4; read issued at col 5; no interference.
- Second mb_start_i during RD → ignored; err_o=1 sticky; first read completes normally.
- MVD_TOP_BYPASS_EN set; mb_x=0 twice with bot_wr_i in the RD cycle, data 18'h2_AAAA → top_mvd_o=18'h2_AAAA. Without the macro: old RAM value.

Source files
------------

// File: rtl/cabac_mvd_pkg.sv
// Shared types and constants for the CABAC top-neighbour MVD line-buffer controller.
// Optional feature macro: MVD_TOP_BYPASS_EN (same-column write-to-read forwarding).
package cabac_mvd_pkg;

    localparam int FMV_W      = 8;
    localparam int MVD_WORD_W = 2 * (FMV_W + 1);
    localparam int ADDR_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_CAP   = 2'd2,
        ST_READY = 2'd3
    } mvd_state_t;

    // Stored word layout is {mvd_y, mvd_x}
    typedef struct packed {
        logic [FMV_W:0] y;
        logic [FMV_W:0] x;
    } mvd_pair_t;

    function automatic logic [MVD_WORD_W-1:0] mvd_pack(input logic [FMV_W:0] y,
                                                       input logic [FMV_W:0] x);
        return {y, x};
    endfunction

    function automatic mvd_pair_t mvd_unpack(input logic [MVD_WORD_W-1:0] word);
        mvd_pair_t p;
        p.y = word[MVD_WORD_W-1 -: FMV_W+1];
        p.x = word[FMV_W:0];
        return p;
    endfunction

endpackage

// File: rtl/cabac_mvd_top_wr_stage.sv
// Write-back register stage: holds the current MB column and issues a one-cycle
// RAM write of the bottom-row MVD word one cycle after bot_wr.
module cabac_mvd_top_wr_stage #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_col,
    input  logic              bot_wr,
    input  logic [WORD_W-1:0] bot_mvd,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [WORD_W-1:0] w_data,
    output logic              orphan
);
    import cabac_mvd_pkg::*;

    logic              have_col;
    logic [ADDR_W-1:0] col;

    // A write with no column latched since reset has nowhere legal to go
    assign orphan = bot_wr & ~have_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            have_col <= 1'b0;
            col      <= '0;
            w_en     <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
        end else begin
            w_en <= bot_wr & have_col;
            // col is read before the start below replaces it, so a coincident
            // write lands on the previous MB's column
            if (bot_wr && have_col) begin
                w_addr <= col;
                w_data <= bot_mvd;
            end
            if (start) begin
                col      <= start_col;
                have_col <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cabac_mvd_top_ctrl.sv
// CABAC top-neighbour MVD line-buffer client: reads the top MVD word at MB start,
// writes the bottom MVD back. Define MVD_TOP_BYPASS_EN to forward same-column writes.
module cabac_mvd_top_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int FMV_W    = 8,
    parameter int MB_X_MAX = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mb_start_i,
    input  logic [ADDR_W-1:0]        mb_x_i,
    input  logic                     mb_y_i,
    input  logic                     bot_wr_i,
    input  logic [2*(FMV_W+1)-1:0]   bot_mvd_i,
    output logic [2*(FMV_W+1)-1:0]   top_mvd_o,
    output logic                     top_avail_o,
    output logic                     top_valid_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic                     r_en_o,
    output logic [ADDR_W-1:0]        r_addr_o,
    input  logic [2*(FMV_W+1)-1:0]   r_data_i,
    output logic                     w_en_o,
    output logic [ADDR_W-1:0]        w_addr_o,
    output logic [2*(FMV_W+1)-1:0]   w_data_o
);
    import cabac_mvd_pkg::*;

    localparam int                WORD_W = 2 * (FMV_W + 1);
    localparam logic [ADDR_W:0]   X_MAX  = (ADDR_W+1)'(MB_X_MAX);

    mvd_state_t        state;
    logic              x_over;
    logic              idle_like;
    logic              start_ok;
    logic              start_err;
    logic              wr_orphan;
    logic [WORD_W-1:0] cap_data;

    assign x_over    = {1'b0, mb_x_i} > X_MAX;
    assign idle_like = (state == ST_IDLE) || (state == ST_READY);
    assign start_ok  = mb_start_i && idle_like && !x_over;
    assign start_err = mb_start_i && (!idle_like || x_over);

    cabac_mvd_top_wr_stage #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_wr (
        .clk       (clk),
        .rst       (rst),
        .start     (start_ok),
        .start_col (mb_x_i),
        .bot_wr    (bot_wr_i),
        .bot_mvd   (bot_mvd_i),
        .w_en      (w_en_o),
        .w_addr    (w_addr_o),
        .w_data    (w_data_o),
        .orphan    (wr_orphan)
    );

`ifdef MVD_TOP_BYPASS_EN
    // The RAM returns old data on a same-cycle collision, so remember a
    // matching write from the RD cycle and catch one happening during CAP.
    logic              fwd_q;
    logic [WORD_W-1:0] fwd_data;
    logic              wr_hit;

    assign wr_hit = w_en_o && (w_addr_o == r_addr_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q    <= 1'b0;
            fwd_data <= '0;
        end else if (state == ST_RD) begin
            fwd_q    <= wr_hit;
            fwd_data <= w_data_o;
        end
    end

    always_comb begin
        cap_data = r_data_i;
        if (wr_hit)
            cap_data = w_data_o;
        else if (fwd_q)
            cap_data = fwd_data;
    end
`else
    assign cap_data = r_data_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            top_mvd_o   <= '0;
            top_avail_o <= 1'b0;
            top_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            r_en_o      <= 1'b0;
            r_addr_o    <= '0;
        end else begin
            r_en_o <= 1'b0;
            if (start_err || wr_orphan)
                err_o <= 1'b1;
            case (state)
                ST_IDLE, ST_READY: begin
                    if (start_ok) begin
                        top_mvd_o   <= '0;
                        top_avail_o <= 1'b0;
                        if (mb_y_i) begin
                            state       <= ST_RD;
                            top_valid_o <= 1'b0;
                            r_en_o      <= 1'b1;
                            r_addr_o    <= mb_x_i;
                            busy_o      <= 1'b1;
                        end else begin
                            // First MB row: no top neighbour, no RAM access
                            state       <= ST_READY;
                            top_valid_o <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    top_mvd_o   <= cap_data;
                    top_avail_o <= 1'b1;
                    top_valid_o <= 1'b1;
                    busy_o      <= 1'b0;
                    state       <= ST_READY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cabac_mvd_top_ctrl.sv
// Directed bench for cabac_mvd_top_ctrl with a behavioural 2-port line-buffer RAM.
module tb_cabac_mvd_top_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mb_start = 1'b0;
    logic [7:0]  mb_x = '0;
    logic        mb_y = 1'b0;
    logic        bot_wr = 1'b0;
    logic [17:0] bot_mvd = '0;
    logic [17:0] top_mvd;
    logic        top_avail, top_valid, busy, err;
    logic        r_en, w_en;
    logic [7:0]  r_addr, w_addr;
    logic [17:0] r_data = '0;
    logic [17:0] w_data;

    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [17:0] pre_data = '0;
    logic [17:0] mem [0:255];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    // Read-before-write RAM: a colliding read returns the old word
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (w_en)
            mem[w_addr] <= w_data;
        if (r_en)
            r_data <= mem[r_addr];
    end

    cabac_mvd_top_ctrl #(
        .ADDR_W   (8),
        .FMV_W    (8),
        .MB_X_MAX (250)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mb_start_i  (mb_start),
        .mb_x_i      (mb_x),
        .mb_y_i      (mb_y),
        .bot_wr_i    (bot_wr),
        .bot_mvd_i   (bot_mvd),
        .top_mvd_o   (top_mvd),
        .top_avail_o (top_avail),
        .top_valid_o (top_valid),
        .busy_o      (busy),
        .err_o       (err),
        .r_en_o      (r_en),
        .r_addr_o    (r_addr),
        .r_data_i    (r_data),
        .w_en_o      (w_en),
        .w_addr_o    (w_addr),
        .w_data_o    (w_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [17:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic start(input logic [7:0] x, input logic y);
        mb_start = 1'b1; mb_x = x; mb_y = y;
    endtask

    initial begin
        logic [17:0] bypass_exp;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 32'(top_valid), 32'd0);
        chk("rst_avail", 32'(top_avail), 32'd0);
        chk("rst_mvd",   32'(top_mvd),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_ren",   32'(r_en),      32'd0);
        chk("rst_wen",   32'(w_en),      32'd0);

        // Write before any start: flagged and dropped
        bot_wr = 1'b1; bot_mvd = 18'h3_0303;
        tick();
        bot_wr = 1'b0;
        chk("orphan_wen", 32'(w_en), 32'd0);
        chk("orphan_err", 32'(err),  32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_err", 32'(err), 32'd0);

        preload(8'd7, 18'h1_2345);
        preload(8'd5, 18'h0_5555);
        preload(8'd0, 18'h0_1111);

        // Row 0: no read, valid after one cycle
        start(8'd5, 1'b0);
        tick();
        mb_start = 1'b0;
        chk("row0_valid", 32'(top_valid), 32'd1);
        chk("row0_avail", 32'(top_avail), 32'd0);
        chk("row0_mvd",   32'(top_mvd),   32'd0);
        chk("row0_ren",   32'(r_en),      32'd0);

        // Read of column 7
        start(8'd7, 1'b1);
        tick();
        mb_start = 1'b0;
        chk("rd7_ren",   32'(r_en),      32'd1);
        chk("rd7_addr",  32'(r_addr),    32'd7);
        chk("rd7_busy",  32'(busy),      32'd1);
        chk("rd7_vlo",   32'(top_valid), 32'd0);
        tick();
        chk("rd7_cap_ren", 32'(r_en),      32'd0);
        chk("rd7_cap_v",   32'(top_valid), 32'd0);
        tick();
        chk("rd7_valid", 32'(top_valid), 32'd1);
        chk("rd7_avail", 32'(top_avail), 32'd1);
        chk("rd7_mvd",   32'(top_mvd),   32'h1_2345);
        chk("rd7_busy0", 32'(busy),      32'd0);

        // Write-back at column 3, then read it back
        start(8'd3, 1'b0);
        tick();
        mb_start = 1'b0;
        bot_wr = 1'b1; bot_mvd = 18'h0_00FF;
        tick();
        bot_wr = 1'b0;
        chk("wr3_wen",  32'(w_en),   32'd1);
        chk("wr3_addr", 32'(w_addr), 32'd3);
        chk("wr3_data", 32'(w_data), 32'h0_00FF);
        tick();
        chk("wr3_pulse", 32'(w_en), 32'd0);
        start(8'd3, 1'b1);
        tick();
        mb_start = 1'b0;
        tick(); tick();
        chk("rb3_mvd", 32'(top_mvd), 32'h0_00FF);

        // Coincident write (col 4) and start (col 5)
        start(8'd4, 1'b0);
        tick();
        start(8'd5, 1'b1);
        bot_wr = 1'b1; bot_mvd = 18'h0_0444;
        tick();
        mb_start = 1'b0; bot_wr = 1'b0;
        chk("co_wen",   32'(w_en),   32'd1);
        chk("co_waddr", 32'(w_addr), 32'd4);
        chk("co_wdata", 32'(w_data), 32'h0_0444);
        chk("co_ren",   32'(r_en),   32'd1);
        chk("co_raddr", 32'(r_addr), 32'd5);
        tick(); tick();
        chk("co_rd5", 32'(top_mvd), 32'h0_5555);
        start(8'd4, 1'b1);
        tick();
        mb_start = 1'b0;
        tick(); tick();
        chk("co_rd4", 32'(top_mvd), 32'h0_0444);

        // Start during RD is ignored and sticky-flagged
        start(8'd7, 1'b1);
        tick();
        start(8'd9, 1'b1);
        tick();
        mb_start = 1'b0;
        chk("dup_err", 32'(err),  32'd1);
        chk("dup_ren", 32'(r_en), 32'd0);
        tick();
        chk("dup_valid", 32'(top_valid), 32'd1);
        chk("dup_mvd",   32'(top_mvd),   32'h1_2345);
        bot_wr = 1'b1; bot_mvd = 18'h0_0001;
        tick();
        bot_wr = 1'b0;
        chk("dup_col", 32'(w_addr), 32'd7);
        tick();
        chk("dup_sticky", 32'(err), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst3_err", 32'(err), 32'd0);

        // mb_x above MB_X_MAX: ignored, FSM holds
        start(8'd3, 1'b0);
        tick();
        start(8'd251, 1'b1);
        tick();
        mb_start = 1'b0;
        chk("rng_err",   32'(err),       32'd1);
        chk("rng_ren",   32'(r_en),      32'd0);
        chk("rng_valid", 32'(top_valid), 32'd1);
        bot_wr = 1'b1; bot_mvd = 18'h0_0002;
        tick();
        bot_wr = 1'b0;
        chk("rng_col", 32'(w_addr), 32'd3);
        rst = 1'b1; tick(); rst = 1'b0;

        // One-column frame: write to col 0 during the RD cycle of the next MB
        start(8'd0, 1'b0);
        tick();
        start(8'd0, 1'b1);
        tick();
        mb_start = 1'b0;
        bot_wr = 1'b1; bot_mvd = 18'h2_AAAA;
        tick();
        bot_wr = 1'b0;
        chk("byp_wen", 32'(w_en), 32'd1);
        tick();
`ifdef MVD_TOP_BYPASS_EN
        bypass_exp = 18'h2_AAAA;
`else
        bypass_exp = 18'h0_1111;
`endif
        chk("byp_mvd", 32'(top_mvd), 32'(bypass_exp));
        chk("byp_err", 32'(err),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
